// File: rtl/uart_pkg.sv
// Shared types and constants for the extended UART receiver.
`timescale 1ns/1ps
package uart_pkg;

   localparam int unsigned MIN_DATA_BITS = 5;

   typedef enum logic [1:0] {
      PAR_NONE = 2'd0,
      PAR_EVEN = 2'd1,
      PAR_ODD  = 2'd2
   } parity_mode_t;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } rx_state_t;

   function automatic logic [3:0] clamp_bits(input logic [3:0] req, input logic [3:0] max_bits);
      if (req < 4'(MIN_DATA_BITS)) return 4'(MIN_DATA_BITS);
      if (req > max_bits) return max_bits;
      return req;
   endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Receive FIFO: circular buffer with extra-MSB pointers, AXI-Stream style read port.
`timescale 1ns/1ps
module uart_rx_fifo #(
   parameter int unsigned WIDTH = 10,
   parameter int unsigned DEPTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   output logic             full,
   output logic [WIDTH-1:0] rd_data,
   output logic             rd_valid,
   input  logic             rd_ready
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [AW:0]      wr_ptr, rd_ptr;
   logic [WIDTH-1:0] mem [DEPTH];
   logic             pop, push;

   assign rd_valid = (wr_ptr != rd_ptr);
   assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign pop      = rd_valid & rd_ready;
   // a same-cycle pop frees the slot, so a write into a full FIFO still lands
   assign push     = wr_en & (~full | pop);
   assign rd_data  = rd_valid ? mem[rd_ptr[AW-1:0]] : '0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr[AW-1:0]] <= wr_data;
   end

endmodule

// File: rtl/uart_rx_ext.sv
// Configurable UART receiver with majority-vote sampling and receive FIFO.
// Optional parity support is built when UART_RX_EXT_PARITY_EN is defined.
`timescale 1ns/1ps
module uart_rx_ext
   import uart_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 9,
   parameter int unsigned FIFO_DEPTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   output logic [DATA_WIDTH-1:0] m_axis_tdata,
   output logic                  m_axis_tuser,
   output logic                  m_axis_tvalid,
   input  logic                  m_axis_tready,
   input  logic                  rxd,
   output logic                  busy,
   output logic                  overrun_error,
   output logic                  frame_error,
   output logic                  parity_error,
   input  logic [15:0]           prescale,
   input  logic [3:0]            data_bits,
   input  logic [1:0]            parity_mode,
   input  logic                  two_stop
);

   rx_state_t       state, state_nx;
   logic            sync1, sync2, prev, fell;
   logic [15:0]     cfg_ps;
   logic [3:0]      cfg_bits;
   parity_mode_t    cfg_par;
   logic            cfg_two;
   logic [18:0]     cnt, half, last;
   logic            s0, s1, bit_val, dec, par_en, complete;
   logic [3:0]      bit_cnt;
   logic            stop_cnt, par_acc, ferr, perr;
   logic [DATA_WIDTH-1:0] sh, word_q;
   logic            done_q, ferr_q, perr_q, tuser_w, fifo_full, pop;
   logic [DATA_WIDTH:0]   rd_word;

   assign fell    = prev & ~sync2;
   assign half    = {1'b0, cfg_ps, 2'b00};
   assign last    = {cfg_ps, 3'b000} - 19'd1;
   assign bit_val = (s0 & s1) | (s0 & sync2) | (s1 & sync2);
   assign dec     = (state != IDLE) && (cnt == half + 19'd1);
`ifdef UART_RX_EXT_PARITY_EN
   assign par_en  = (cfg_par != PAR_NONE);
   assign tuser_w = ferr_q | perr_q;
   assign parity_error = done_q & perr_q;
`else
   assign par_en  = 1'b0;
   assign tuser_w = ferr_q;
   assign parity_error = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      complete = 1'b0;
      case (state)
         IDLE:   if (fell) state_nx = START;
         START:  if (dec) state_nx = bit_val ? IDLE : DATA;
         DATA:   if (dec && bit_cnt == cfg_bits - 4'd1) state_nx = par_en ? PARITY : STOP;
         PARITY: if (dec) state_nx = STOP;
         STOP:   if (dec && stop_cnt == cfg_two) begin
            state_nx = IDLE;
            complete = 1'b1;
         end
         default: state_nx = IDLE;
      endcase
   end

   // the bit counter free-runs per period, so every state decides at the same mid-bit offset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1 <= 1'b1; sync2 <= 1'b1; prev <= 1'b1;
         cfg_ps <= '0; cfg_bits <= '0; cfg_par <= PAR_NONE; cfg_two <= 1'b0;
         cnt <= '0; s0 <= 1'b0; s1 <= 1'b0;
         bit_cnt <= '0; stop_cnt <= 1'b0; par_acc <= 1'b0; ferr <= 1'b0; perr <= 1'b0;
         sh <= '0; word_q <= '0; done_q <= 1'b0; ferr_q <= 1'b0; perr_q <= 1'b0;
      end else begin
         sync1  <= rxd;
         sync2  <= sync1;
         prev   <= sync2;
         done_q <= complete;
         if (state == IDLE || cnt == last) cnt <= '0;
         else                              cnt <= cnt + 19'd1;
         if (state == IDLE && fell) begin
            cfg_ps   <= (prescale == '0) ? 16'd1 : prescale;
            cfg_bits <= clamp_bits(data_bits, 4'(DATA_WIDTH));
            cfg_par  <= (parity_mode == 2'd1) ? PAR_EVEN :
                        (parity_mode == 2'd2) ? PAR_ODD : PAR_NONE;
            cfg_two  <= two_stop;
            bit_cnt <= '0; stop_cnt <= 1'b0; par_acc <= 1'b0;
            ferr <= 1'b0; perr <= 1'b0; sh <= '0;
         end
         if (cnt == half - 19'd1) s0 <= sync2;
         if (cnt == half)         s1 <= sync2;
         if (dec) begin
            case (state)
               DATA: begin
                  sh      <= {bit_val, sh[DATA_WIDTH-1:1]};
                  par_acc <= par_acc ^ bit_val;
                  bit_cnt <= bit_cnt + 4'd1;
               end
               PARITY: perr <= bit_val ^ par_acc ^ (cfg_par == PAR_ODD);
               STOP: begin
                  stop_cnt <= 1'b1;
                  if (!bit_val) ferr <= 1'b1;
               end
               default: ;
            endcase
         end
         if (complete) begin
            word_q <= sh >> (4'(DATA_WIDTH) - cfg_bits);
            ferr_q <= ferr | ~bit_val;
            perr_q <= perr;
         end
      end
   end

   assign pop           = m_axis_tvalid & m_axis_tready;
   assign busy          = (state != IDLE);
   assign frame_error   = done_q & ferr_q;
   assign overrun_error = done_q & fifo_full & ~pop;
   assign m_axis_tdata  = rd_word[DATA_WIDTH-1:0];
   assign m_axis_tuser  = rd_word[DATA_WIDTH];

   uart_rx_fifo #(
      .WIDTH(DATA_WIDTH + 1),
      .DEPTH(FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (done_q),
      .wr_data ({tuser_w, word_q}),
      .full    (fifo_full),
      .rd_data (rd_word),
      .rd_valid(m_axis_tvalid),
      .rd_ready(m_axis_tready)
   );

endmodule

// File: tb/tb_uart_rx_ext.sv
// Scoreboard bench for uart_rx_ext: directed frames, expected words queued, monitor pops on handshake.
`timescale 1ns/1ps
module tb_uart_rx_ext;

   localparam int DW = 9;
   localparam int FD = 4;
   localparam int P  = 16;

   logic          clk, rst, rxd, m_axis_tready, m_axis_tvalid, m_axis_tuser;
   logic [DW-1:0] m_axis_tdata;
   logic          busy, overrun_error, frame_error, parity_error, two_stop;
   logic [15:0]   prescale;
   logic [3:0]    data_bits;
   logic [1:0]    parity_mode;

   int passed = 0;
   int total  = 0;
   int n_ferr = 0, n_perr = 0, n_ovr = 0, busy_cycles = 0;
   int saw_busy, ferr_snap, perr_snap, ovr_snap;
   logic [DW:0] exp_q[$];
   logic [DW:0] mon_exp;

   uart_rx_ext #(.DATA_WIDTH(DW), .FIFO_DEPTH(FD)) dut (
      .clk(clk), .rst(rst),
      .m_axis_tdata(m_axis_tdata), .m_axis_tuser(m_axis_tuser),
      .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
      .rxd(rxd), .busy(busy), .overrun_error(overrun_error),
      .frame_error(frame_error), .parity_error(parity_error),
      .prescale(prescale), .data_bits(data_bits),
      .parity_mode(parity_mode), .two_stop(two_stop)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (frame_error)   n_ferr++;
      if (parity_error)  n_perr++;
      if (overrun_error) n_ovr++;
      if (busy)          busy_cycles++;
   end

   always @(negedge clk) begin
      if (!rst && m_axis_tvalid && m_axis_tready) begin
         total++;
         if (exp_q.size() == 0) begin
            $display("FAIL word: got tuser=%0d tdata=%h, required no word", m_axis_tuser, m_axis_tdata);
         end else begin
            mon_exp = exp_q.pop_front();
            if ({m_axis_tuser, m_axis_tdata} == mon_exp) passed++;
            else $display("FAIL word: got tuser=%0d tdata=%h, required tuser=%0d tdata=%h",
                          m_axis_tuser, m_axis_tdata, mon_exp[DW], mon_exp[DW-1:0]);
         end
      end
   end

   task automatic chk(input string name, input int act, input int req);
      total++;
      if (act == req) passed++;
      else $display("FAIL %s: got %0d, required %0d", name, act, req);
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic drive_bit(input logic v, input bit glitch);
      for (int c = 0; c < P; c++) begin
         @(negedge clk);
         rxd = (glitch && c == 9) ? ~v : v;
      end
   endtask

   task automatic send(input logic [8:0] data, input int nbits, input int par,
                       input int nstop, input bit stop_low, input int glitch_bit);
      drive_bit(1'b0, 1'b0);
      for (int b = 0; b < nbits; b++) drive_bit(data[b], b == glitch_bit);
      if (par >= 0) drive_bit(par[0], 1'b0);
      for (int s = 0; s < nstop; s++) drive_bit(~stop_low, 1'b0);
      @(negedge clk);
      rxd = 1'b1;
      idle(P);
   endtask

   initial begin
      rst = 1'b1; rxd = 1'b1; m_axis_tready = 1'b1;
      prescale = 16'd2; data_bits = 4'd8; parity_mode = 2'd0; two_stop = 1'b0;
      idle(3);
      chk("reset_tvalid", m_axis_tvalid, 0);
      chk("reset_tdata", m_axis_tdata, 0);
      chk("reset_busy", busy, 0);
      chk("reset_errors", {overrun_error, frame_error, parity_error}, 0);
      rst = 1'b0;
      idle(5);

      // 8N1 0xA5
      busy_cycles = 0;
      exp_q.push_back({1'b0, 9'h0A5});
      send(9'h0A5, 8, -1, 1, 1'b0, -1);
      idle(P);
      chk("busy_len_in_148_160", int'(busy_cycles inside {[148:160]}), 1);
      chk("a5_no_frame_err", n_ferr, 0);
      chk("a5_no_overrun", n_ovr, 0);

      // 7-bit, two stop bits, parity frames
      data_bits = 4'd7; two_stop = 1'b1; parity_mode = 2'd1;
`ifdef UART_RX_EXT_PARITY_EN
      exp_q.push_back({1'b0, 9'h041});
      send(9'h041, 7, 0, 2, 1'b0, -1);
      exp_q.push_back({1'b1, 9'h041});
      send(9'h041, 7, 1, 2, 1'b0, -1);
      idle(P);
      chk("parity_err_pulses", n_perr, 1);
`else
      exp_q.push_back({1'b0, 9'h041});
      send(9'h041, 7, -1, 2, 1'b0, -1);
      exp_q.push_back({1'b0, 9'h041});
      send(9'h041, 7, -1, 2, 1'b0, -1);
      idle(P);
      chk("parity_err_pulses", n_perr, 0);
`endif
      chk("parity_no_frame_err", n_ferr, 0);

      // 9N1 with low stop bit
      data_bits = 4'd9; two_stop = 1'b0; parity_mode = 2'd0;
      exp_q.push_back({1'b1, 9'h1FF});
      send(9'h1FF, 9, -1, 1, 1'b1, -1);
      idle(P);
      chk("frame_err_pulses", n_ferr, 1);

      // false start: 5 low clocks
      data_bits = 4'd8;
      saw_busy = 0;
      @(negedge clk); rxd = 1'b0;
      idle(5);
      rxd = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (busy) saw_busy = 1;
      end
      idle(2 * P);
      chk("false_start_busy_seen", saw_busy, 1);
      chk("false_start_busy_clear", busy, 0);
      chk("false_start_no_word", exp_q.size(), 0);
      exp_q.push_back({1'b0, 9'h03C});
      send(9'h03C, 8, -1, 1, 1'b0, -1);

      // glitch on mid-bit of data bit 3
      exp_q.push_back({1'b0, 9'h000});
      send(9'h000, 8, -1, 1, 1'b0, 3);
      idle(P);

      // overrun with tready held low
      m_axis_tready = 1'b0;
      ovr_snap = n_ovr;
      exp_q.push_back({1'b0, 9'h011});
      exp_q.push_back({1'b0, 9'h022});
      exp_q.push_back({1'b0, 9'h033});
      exp_q.push_back({1'b0, 9'h044});
      send(9'h011, 8, -1, 1, 1'b0, -1);
      send(9'h022, 8, -1, 1, 1'b0, -1);
      send(9'h033, 8, -1, 1, 1'b0, -1);
      send(9'h044, 8, -1, 1, 1'b0, -1);
      send(9'h055, 8, -1, 1, 1'b0, -1);
      chk("overrun_pulses", n_ovr - ovr_snap, 1);
      chk("overrun_tvalid_held", m_axis_tvalid, 1);
      chk("overrun_tdata_head", m_axis_tdata, 9'h011);
      m_axis_tready = 1'b1;
      idle(10);
      chk("drain_complete", exp_q.size(), 0);

      // reset mid-frame with one word held in the FIFO
      m_axis_tready = 1'b0;
      send(9'h066, 8, -1, 1, 1'b0, -1);
      ferr_snap = n_ferr; perr_snap = n_perr; ovr_snap = n_ovr;
      @(negedge clk); rxd = 1'b0;
      idle(3 * P);
      rst = 1'b1;
      @(negedge clk);
      chk("midrst_tvalid", m_axis_tvalid, 0);
      chk("midrst_tdata", m_axis_tdata, 0);
      chk("midrst_busy", busy, 0);
      rxd = 1'b1;
      idle(2);
      rst = 1'b0;
      m_axis_tready = 1'b1;
      idle(2 * P);
      chk("postrst_fifo_empty", m_axis_tvalid, 0);
      chk("postrst_no_err", (n_ferr - ferr_snap) + (n_perr - perr_snap) + (n_ovr - ovr_snap), 0);

      chk("all_words_seen", exp_q.size(), 0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/uart_rx_ext.md
# uart_rx_ext

Parametrised UART receiver: the successor to the fixed 8N1 `uart_rx` used in the UART_ALU front end. It adds run-time data width, parity and stop-bit selection, 3-sample majority-vote bit decisions and an internal receive FIFO. Received characters leave on an AXI-Stream master port with per-word error flags, feeding the ALU command parser.

## Interface
- `DATA_WIDTH`, default 9: maximum character width in bits; legal range 5..9.
- `FIFO_DEPTH`, default 8: receive FIFO entries; power of two, at least 2.
- `clk` in 1: single clock; every flop is clocked on its rising edge.
- `rst` in 1: **asynchronous, active-high** reset.
- `m_axis_tdata` out DATA_WIDTH: received character, LSB-aligned, unused upper bits 0.
- `m_axis_tuser` out 1: 1 = this word had a frame or parity error.
- `m_axis_tvalid` out 1: FIFO non-empty.
- `m_axis_tready` in 1: downstream accepts the word.
- `rxd` in 1: serial input, asynchronous to `clk`, idle high.
- `busy` out 1: a frame is being received.
- `overrun_error` out 1: one-cycle pulse when a completed character is dropped because the FIFO is full.
- `frame_error` out 1: one-cycle pulse when a stop bit is sampled low.
- `parity_error` out 1: one-cycle pulse when the parity bit mismatches.
- `prescale` in 16: bit period P = 8·prescale clocks; a value of 0 is treated as 1.
- `data_bits` in 4: character width, clamped to the range 5..DATA_WIDTH.
- `parity_mode` in 2: 0 none, 1 even, 2 odd, 3 none.
- `two_stop` in 1: 1 = two stop bits.

## Operation
- `rxd` passes through a 2-flop synchroniser that resets to 1. All decisions use the synchronised value.
- Configuration inputs are captured on start detection and held for the whole frame.
- State machine states: IDLE, START, DATA, PARITY, STOP.
  - IDLE → START on a falling edge of the synchronised `rxd`.
  - START: sample at mid-bit. A majority result of 1 is a false start and returns to IDLE with no output. A result of 0 goes to DATA.
  - DATA: receive `data_bits` bits, LSB first, one every P clocks. Then go to PARITY if parity is enabled, otherwise to STOP.
  - PARITY: one bit. Check it against the even/odd XOR of the data bits.
  - STOP: one or two stop bits. The frame completes at the majority decision of the last stop bit, then the machine returns to IDLE.
- Returning to IDLE at mid-stop-bit allows back-to-back frames with at most ±half-bit drift.
- Majority vote: three consecutive clocks centred on mid-bit (counter = P/2−1, P/2, P/2+1). The bit value is 1 when at least two samples are 1.
- At frame completion:
  - The data word is written to the FIFO with `tuser` = frame_err | parity_err.
  - The error pulse outputs fire in that same cycle.
  - If the FIFO is full and no pop occurs that cycle, the word is dropped and `overrun_error` pulses. A pop in the same cycle frees the slot and the write succeeds.
- `busy` is 1 from the cycle after start detection until the cycle after frame completion; it is also 0 after a false start.
- FIFO: circular buffer with log2(FIFO_DEPTH)+1-bit pointers, so full/empty use wrap-around compare. A pop occurs when `m_axis_tvalid & m_axis_tready`.

## Timing
- Reset values:
  - All outputs 0, including `m_axis_tvalid` and `m_axis_tdata`.
  - Synchroniser flops 1, FIFO empty, state IDLE, all counters 0.
- Reset mid-frame aborts the frame and empties the FIFO. No error pulse is produced.
- Start detection occurs 2 clocks after the `rxd` falling edge (synchroniser delay).
- The FIFO write occurs 1 clock after the decision of the last stop bit. `m_axis_tvalid` rises 1 clock after the write.
- `m_axis_tdata`/`m_axis_tuser` are stable while `tvalid & !tready`, as the AXI-Stream rules require.
- Changes to `prescale` or the configuration inputs mid-frame have no effect until the next start bit.

## Configuration
- Macro: `UART_RX_EXT_PARITY_EN`.
- Defined: the PARITY state and parity checker are built, `parity_mode` is honoured, and `parity_error` is live.
- Undefined:
  - `parity_mode` is ignored and no parity bit is expected.
  - `parity_error` is tied to 0.
  - `tuser` reflects frame errors only.

## Structure
- Package `uart_pkg`:
  - `parity_mode_t` enum (PAR_NONE, PAR_EVEN, PAR_ODD).
  - `rx_state_t` enum.
  - `MIN_DATA_BITS` = 5.
- Sub-module `uart_rx_fifo`:
  - Parameters: width (DATA_WIDTH+1) and FIFO_DEPTH.
  - Write port with full flag; read port with AXI-Stream valid/ready.
  - Asynchronous reset `rst`.

## Test plan
- prescale=2 (P=16), 8N1, send 0xA5 → one word `tdata`=0xA5, `tuser`=0, no error pulses, `busy` high for ~9.5·16 clocks.
- 7E2, send 0x41 with a correct parity bit, then again with parity inverted → first word `tuser`=0; second `tuser`=1 with a single `parity_error` pulse.
- 9N1, send 0x1FF with the stop bit driven low → `tdata`=0x1FF, `tuser`=1, one `frame_error` pulse.
- `rxd` low for 5 clocks only (P=16) → false start: no word, `busy` returns to 0, next valid frame received correctly.
- FIFO_DEPTH=4, `tready`=0, send 5 characters → 4 words held, one `overrun_error` pulse. Raise `tready` → words 1..4 drain in order.
- Single-sample glitch at the mid-bit of data bit 3 of 0x00 → majority vote gives `tdata`=0x00. Assert `rst` mid-frame → all outputs 0, FIFO empty.
